// File: rtl/lif_spike_packer.sv
`default_nettype none
// ============================================================================
//  Module      : lif_spike_packer
//  Description : Packs per-neuron TIME_STEPS-bit spike vectors into
//                OUT_WIDTH-bit words and buffers them in a show-ahead FIFO
//                feeding a valid/ready stream. Upstream cannot stall, so a
//                word completed while the FIFO is full is dropped and a
//                sticky overflow flag is raised.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_spike_packer #(
  parameter int TIME_STEPS = 4,   // spike bits per neuron
  parameter int OUT_WIDTH  = 64,  // packed word width, multiple of TIME_STEPS
  parameter int FIFO_DEPTH = 8    // power of two, >= 2
) (
  input  logic                          s_clk,
  input  logic                          s_rst,
  input  logic                          i_spikes_valid,
  input  logic [TIME_STEPS-1:0]         i_spikes,
  input  logic                          i_spikes_last,
  output logic [OUT_WIDTH-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_last,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_overflow
);

  localparam int SLOTS  = OUT_WIDTH / TIME_STEPS;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Packer state
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [OUT_WIDTH-1:0]  pack_q, pack_d;

  // FIFO state; each entry carries {last, word}
  logic [OUT_WIDTH:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  overflow_q;

  // Datapath / handshake wires
  logic [OUT_WIDTH-1:0]  merged_word;
  logic                  word_done;
  logic                  pop;
  logic                  push_ok;

  // Current vector merged into its slot of the pack register
  always_comb begin
    merged_word = pack_q;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_cnt_q == SLOT_W'(s)) begin
        merged_word[s*TIME_STEPS +: TIME_STEPS] = i_spikes;
      end
    end
  end

  // Word completion, FIFO handshake and next-state of packer and count
  always_comb begin
    word_done  = i_spikes_valid && ((slot_cnt_q == SLOT_MAX) || i_spikes_last);
    pop        = o_valid && i_ready;
    // A full FIFO still takes the word when the head leaves on the same edge
    push_ok    = word_done && ((cnt_q < CNT_FULL) || pop);

    slot_cnt_d = slot_cnt_q;
    pack_d     = pack_q;
    if (i_spikes_valid) begin
      if (word_done) begin
        // The packer advances even when the word is dropped
        slot_cnt_d = '0;
        pack_d     = '0;
      end else begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        pack_d     = merged_word;
      end
    end

    cnt_d = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Packer, pointers, occupancy and sticky overflow registers
  always_ff @(posedge s_clk) begin
    if (!s_rst) begin
      slot_cnt_q <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      pack_q     <= pack_d;
      cnt_q      <= cnt_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (word_done && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge s_clk) begin
    if (s_rst && push_ok) begin
      mem_q[wr_ptr_q] <= {i_spikes_last, merged_word};
    end
  end

  assign o_data     = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign o_last     = mem_q[rd_ptr_q][OUT_WIDTH];
  assign o_valid    = (cnt_q != '0);
  assign o_fifo_cnt = cnt_q;
  assign o_overflow = overflow_q;

endmodule
`default_nettype wire
